// File: rtl/apu_pulse_ch_regs.sv
// CPU-facing register file and timers for one APU pulse channel (NRx1..NRx4).
// Define APU_CNT_READBACK_EN to expose the live period counter on NRx3/NRx4 reads.
module apu_pulse_ch_regs #(
  parameter int FREQ_W = 11,
  parameter int LEN_W  = 6,
  parameter int ENV_W  = 8
) (
  input  logic             clk,
  input  logic             napu_reset,
  input  logic [1:0]       reg_sel,
  input  logic             apu_wr,
  input  logic             apu_rd,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic             freq_clk_en,
  input  logic             len_clk_en,
  output logic [1:0]       duty,
  output logic [ENV_W-1:0] env_reg,
  output logic             freq_tick,
  output logic             trig,
  output logic             ch_active
);

  logic [1:0]        duty_q, duty_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [FREQ_W-1:0] period_q, period_d;
  logic              len_en_q, len_en_d;
  logic [FREQ_W-1:0] per_cnt_q, per_cnt_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic              len_exp_q, len_exp_d;
  logic              ch_active_q, ch_active_d;
  logic              trig_q, trig_d;
  logic              freq_tick_q, freq_tick_d;

  logic wr_nrx1, wr_nrx2, wr_nrx3, wr_nrx4;
  logic trig_now;
  logic dac_on_d;

  assign wr_nrx1  = apu_wr && (reg_sel == 2'd0);
  assign wr_nrx2  = apu_wr && (reg_sel == 2'd1);
  assign wr_nrx3  = apu_wr && (reg_sel == 2'd2);
  assign wr_nrx4  = apu_wr && (reg_sel == 2'd3);
  assign trig_now = wr_nrx4 && wdata[7];

  always_comb begin
    duty_d   = duty_q;
    env_d    = env_q;
    period_d = period_q;
    len_en_d = len_en_q;
    if (wr_nrx1) duty_d = wdata[7:6];
    if (wr_nrx2) env_d = ENV_W'(wdata);
    if (wr_nrx3) period_d[7:0] = wdata;
    if (wr_nrx4) begin
      period_d[FREQ_W-1:8] = wdata[FREQ_W-9:0];
      len_en_d             = wdata[6];
    end
  end

  assign dac_on_d = (env_d[ENV_W-1:3] != '0);

  // A trigger reload takes priority over a coincident overflow and swallows its tick.
  always_comb begin
    per_cnt_d   = per_cnt_q;
    freq_tick_d = 1'b0;
    if (trig_now) begin
      per_cnt_d = period_d;
    end else if (freq_clk_en) begin
      if (per_cnt_q == '1) begin
        per_cnt_d   = period_d;
        freq_tick_d = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + FREQ_W'(1);
      end
    end
  end

  // len_exp_q parks the length counter at zero after expiry until NRx1 or a trigger re-arms it.
  always_comb begin
    len_cnt_d   = len_cnt_q;
    len_exp_d   = len_exp_q;
    ch_active_d = ch_active_q;
    if (wr_nrx1) begin
      len_cnt_d = LEN_W'(wdata);
      len_exp_d = 1'b0;
    end else if (trig_now) begin
      if (len_cnt_q == '1) len_cnt_d = '0;
      len_exp_d = 1'b0;
    end else if (len_clk_en && len_en_q && !len_exp_q) begin
      if (len_cnt_q == '1) begin
        len_cnt_d   = '0;
        len_exp_d   = 1'b1;
        ch_active_d = 1'b0;
      end else begin
        len_cnt_d = len_cnt_q + LEN_W'(1);
      end
    end
    if (trig_now) ch_active_d = dac_on_d;
    if (wr_nrx2 && !dac_on_d) ch_active_d = 1'b0;
  end

  assign trig_d = trig_now;

  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      duty_q      <= '0;
      env_q       <= '0;
      period_q    <= '0;
      len_en_q    <= 1'b0;
      per_cnt_q   <= '0;
      len_cnt_q   <= '0;
      len_exp_q   <= 1'b0;
      ch_active_q <= 1'b0;
      trig_q      <= 1'b0;
      freq_tick_q <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      env_q       <= env_d;
      period_q    <= period_d;
      len_en_q    <= len_en_d;
      per_cnt_q   <= per_cnt_d;
      len_cnt_q   <= len_cnt_d;
      len_exp_q   <= len_exp_d;
      ch_active_q <= ch_active_d;
      trig_q      <= trig_d;
      freq_tick_q <= freq_tick_d;
    end
  end

  logic [7:0] rd_nrx2, rd_nrx3, rd_nrx4;

  always_comb begin
    rd_nrx2            = 8'hFF;
    rd_nrx2[ENV_W-1:0] = env_q;
  end

`ifdef APU_CNT_READBACK_EN
  assign rd_nrx3 = per_cnt_q[7:0];
  assign rd_nrx4 = {1'b1, len_en_q, {(14-FREQ_W){1'b1}}, per_cnt_q[FREQ_W-1:8]};
`else
  assign rd_nrx3 = 8'hFF;
  assign rd_nrx4 = {1'b1, len_en_q, 6'h3F};
`endif

  always_comb begin
    rdata = 8'hFF;
    if (apu_rd) begin
      case (reg_sel)
        2'd0:    rdata = {duty_q, 6'h3F};
        2'd1:    rdata = rd_nrx2;
        2'd2:    rdata = rd_nrx3;
        default: rdata = rd_nrx4;
      endcase
    end
  end

  assign duty      = duty_q;
  assign env_reg   = env_q;
  assign freq_tick = freq_tick_q;
  assign trig      = trig_q;
  assign ch_active = ch_active_q;

endmodule
